// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes and ALUOp codes.
package mips_defs;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_I_EXEC   = 4'd10;
    localparam logic [3:0] S_I_WB     = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam logic [3:0] ALUOP_RTYPE = 4'b0000;
    localparam logic [3:0] ALUOP_ADD   = 4'b1000;
    localparam logic [3:0] ALUOP_SUB   = 4'b0100;
    localparam logic [3:0] ALUOP_SLT   = 4'b1010;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI: op_legal = 1'b1;
            default:                                            op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational map from FSM state, latched opcode and memory ready to datapath controls.
module ctrl_out_decode
    import mips_defs::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op_q,
    input  logic [5:0] instr_op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALUOP_RTYPE;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_ADD;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            // The opcode is not latched yet in DECODE, so the live IR field is used here.
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALUOP_ADD;
                illegal   = ~op_legal(instr_op);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (op_q == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main multi-cycle MIPS control FSM: sequences instruction phases, stalls on memory ready, counts retirements.
module multicycle_ctrl
    import mips_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       instr_op_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic             ir_write_o,
    output logic             i_or_d_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             reg_dst_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [3:0]       alu_op_o,
    output logic [1:0]       pc_source_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    logic [3:0]       state, state_nxt;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] instr_cnt;
    logic             retire;

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (mem_ready_i) state_nxt = S_DECODE;
            S_DECODE: begin
                case (instr_op_i)
                    OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
                    OP_R:             state_nxt = S_R_EXEC;
                    OP_BEQ:           state_nxt = S_BRANCH;
                    OP_J:             state_nxt = S_JUMP;
                    OP_ADDI, OP_SLTI: state_nxt = S_I_EXEC;
                    default:          state_nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_nxt = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready_i) state_nxt = S_MEM_WB;
            S_MEM_WR:   if (mem_ready_i) state_nxt = S_FETCH;
            S_R_EXEC:   state_nxt = S_R_WB;
            S_I_EXEC:   state_nxt = S_I_WB;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // An illegal opcode returns from DECODE without retiring anything.
    assign retire = (state_nxt == S_FETCH) && (state != S_FETCH) && (state != S_DECODE);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_FETCH;
            op_q      <= 6'd0;
            instr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) op_q <= instr_op_i;
            if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    ctrl_out_decode u_out (
        .state         (state),
        .op_q          (op_q),
        .instr_op      (instr_op_i),
        .mem_ready     (mem_ready_i),
        .pc_write      (pc_write_o),
        .pc_write_cond (pc_write_cond_o),
        .ir_write      (ir_write_o),
        .i_or_d        (i_or_d_o),
        .mem_read      (mem_read_o),
        .mem_write     (mem_write_o),
        .mem_to_reg    (mem_to_reg_o),
        .reg_dst       (reg_dst_o),
        .reg_write     (reg_write_o),
        .alu_src_a     (alu_src_a_o),
        .alu_src_b     (alu_src_b_o),
        .alu_op        (alu_op_o),
        .pc_source     (pc_source_o),
        .illegal       (illegal_o)
    );

    assign state_o     = state;
    assign instr_cnt_o = instr_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expectations queued at drive time, checked mid-cycle.
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [5:0]       instr_op_i;
    logic             mem_ready_i;
    logic             pc_write_o, pc_write_cond_o, ir_write_o, i_or_d_o;
    logic             mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o;
    logic             alu_src_a_o, illegal_o;
    logic [1:0]       alu_src_b_o, pc_source_o;
    logic [3:0]       alu_op_o, state_o;
    logic [CNT_W-1:0] instr_cnt_o;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic [3:0]       state;
        ctl_t             ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    assert_cnt = 0;
    int    fail_cnt   = 0;

    always #5 clk_i = ~clk_i;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .instr_op_i      (instr_op_i),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .ir_write_o      (ir_write_o),
        .i_or_d_o        (i_or_d_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .reg_dst_o       (reg_dst_o),
        .reg_write_o     (reg_write_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .alu_op_o        (alu_op_o),
        .pc_source_o     (pc_source_o),
        .illegal_o       (illegal_o),
        .state_o         (state_o),
        .instr_cnt_o     (instr_cnt_o)
    );

    // Expected control word per state, transcribed from the output table.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (st)
            4'd0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 4'b1000;
                         c.pc_write = rdy; c.ir_write = rdy; end
            4'd1:  begin c.alu_src_b = 2'b11; c.alu_op = 4'b1000;
                         c.illegal = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                                  6'b000010, 6'b001000, 6'b001010}); end
            4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 4'b1000; end
            4'd3:  begin c.mem_read = 1; c.i_or_d = 1; end
            4'd4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
            4'd5:  begin c.mem_write = 1; c.i_or_d = 1; end
            4'd6:  begin c.alu_src_a = 1; c.alu_op = 4'b0000; end
            4'd7:  begin c.reg_dst = 1; c.reg_write = 1; end
            4'd8:  begin c.alu_src_a = 1; c.alu_op = 4'b0100; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            4'd9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
            4'd10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10;
                         c.alu_op = (op == 6'b001010) ? 4'b1010 : 4'b1000; end
            4'd11: begin c.reg_write = 1; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic check_out();
        exp_t  e;
        string t;
        ctl_t  got;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = '{pc_write_o, pc_write_cond_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
                mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                pc_source_o, illegal_o};
        assert_cnt++;
        assert (state_o === e.state) else begin
            fail_cnt++;
            $error("FAIL %s state: observed %0d expected %0d", t, state_o, e.state);
        end
        assert_cnt++;
        assert (got === e.ctl) else begin
            fail_cnt++;
            $error("FAIL %s ctl: observed %b expected %b", t, got, e.ctl);
        end
        assert_cnt++;
        assert (instr_cnt_o === e.cnt) else begin
            fail_cnt++;
            $error("FAIL %s cnt: observed %0d expected %0d", t, instr_cnt_o, e.cnt);
        end
    endtask

    // Drive inputs, queue the expectation, then check once the outputs have settled.
    task automatic drive(input string tag, input logic [5:0] op, input logic rdy,
                         input logic [3:0] st, input int cnt);
        instr_op_i  = op;
        mem_ready_i = rdy;
        exp_q.push_back('{st, exp_ctl(st, rdy, op), CNT_W'(cnt)});
        tag_q.push_back(tag);
        #1;
        check_out();
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input int cnt);
        drive(tag, op, rdy, st, cnt);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i       = 1'b0;
        instr_op_i  = 6'd0;
        mem_ready_i = 1'b0;

        drive("rst_rdy0", 6'b000000, 1'b0, 4'd0, 0);
        #2;
        drive("rst_rdy1", 6'b000000, 1'b1, 4'd0, 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // R-type, zero wait states
        step("r_fetch",  6'b000000, 1'b1, 4'd0, 0);
        step("r_decode", 6'b000000, 1'b1, 4'd1, 0);
        step("r_exec",   6'b000000, 1'b1, 4'd6, 0);
        step("r_wb",     6'b000000, 1'b1, 4'd7, 0);

        // lw with two wait cycles in MEM_RD
        step("lw_fetch",  6'b100011, 1'b1, 4'd0, 1);
        step("lw_decode", 6'b100011, 1'b1, 4'd1, 1);
        step("lw_addr",   6'b100011, 1'b0, 4'd2, 1);
        step("lw_rd_w0",  6'b100011, 1'b0, 4'd3, 1);
        step("lw_rd_w1",  6'b100011, 1'b0, 4'd3, 1);
        step("lw_rd",     6'b100011, 1'b1, 4'd3, 1);
        step("lw_wb",     6'b100011, 1'b0, 4'd4, 1);

        // beq with ready low outside memory states (must be ignored)
        step("beq_fetch",  6'b000100, 1'b1, 4'd0, 2);
        step("beq_decode", 6'b000100, 1'b0, 4'd1, 2);
        step("beq_branch", 6'b000100, 1'b0, 4'd8, 2);

        step("addi_fetch",  6'b001000, 1'b1, 4'd0, 3);
        step("addi_decode", 6'b001000, 1'b1, 4'd1, 3);
        step("addi_exec",   6'b001000, 1'b1, 4'd10, 3);
        step("addi_wb",     6'b001000, 1'b1, 4'd11, 3);
        step("slti_fetch",  6'b001010, 1'b1, 4'd0, 4);
        step("slti_decode", 6'b001010, 1'b1, 4'd1, 4);
        step("slti_exec",   6'b001010, 1'b1, 4'd10, 4);
        step("slti_wb",     6'b001010, 1'b1, 4'd11, 4);

        step("sw_fetch",  6'b101011, 1'b1, 4'd0, 5);
        step("sw_decode", 6'b101011, 1'b1, 4'd1, 5);
        step("sw_addr",   6'b101011, 1'b1, 4'd2, 5);
        step("sw_wr",     6'b101011, 1'b1, 4'd5, 5);

        // j with a stalled fetch first
        step("j_fetch_w", 6'b000010, 1'b0, 4'd0, 6);
        step("j_fetch",   6'b000010, 1'b1, 4'd0, 6);
        step("j_decode",  6'b000010, 1'b1, 4'd1, 6);
        step("j_jump",    6'b000010, 1'b1, 4'd9, 6);

        // illegal opcode: back to FETCH without counting
        step("ill_fetch",  6'b111111, 1'b1, 4'd0, 7);
        step("ill_decode", 6'b111111, 1'b1, 4'd1, 7);
        step("ill_after",  6'b111111, 1'b0, 4'd0, 7);

        // sw stalled in MEM_WR, then asynchronous reset between clock edges
        step("sw2_fetch",  6'b101011, 1'b1, 4'd0, 7);
        step("sw2_decode", 6'b101011, 1'b1, 4'd1, 7);
        step("sw2_addr",   6'b101011, 1'b0, 4'd2, 7);
        step("sw2_wr_w0",  6'b101011, 1'b0, 4'd5, 7);
        drive("sw2_wr_w1", 6'b101011, 1'b0, 4'd5, 7);
        #1;
        rst_i = 1'b0;
        drive("async_rst", 6'b101011, 1'b0, 4'd0, 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        step("post_fetch",  6'b000000, 1'b1, 4'd0, 0);
        step("post_decode", 6'b000000, 1'b1, 4'd1, 0);
        step("post_exec",   6'b000000, 1'b1, 4'd6, 0);
        step("post_wb",     6'b000000, 1'b1, 4'd7, 0);
        step("post_done",   6'b000000, 1'b0, 4'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
